// File: rtl/segment_scanner.sv
// segment_scanner: time-multiplexes per-digit seven-segment patterns onto a
// shared active-low cathode bus with one active-low anode per digit.
// A full-frame snapshot of the input is taken at every frame wrap so a digit
// never shows a half-updated value.
//
// Optional feature macro: SEGMENT_SCANNER_BLANK_EN
//   defined   -> the first BlankCycles cycles of every digit slot are dark
//                (anti-ghosting dead-time)
//   undefined -> every slot cycle drives its digit; BlankCycles is ignored

// Shared calculator constants; the scanner only needs the digit count.
package calc_pkg;
    parameter int NumDigits = 8;
endpackage

module segment_scanner #(
    parameter int ClkPerDigit = 1024,
    parameter int BlankCycles = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [calc_pkg::NumDigits-1:0][7:0]   display_segments_i,
    input  logic                                  blank_i,
    output logic [7:0]                            segments_cathode_o,
    output logic [calc_pkg::NumDigits-1:0]        segments_anode_o,
    output logic                                  frame_o
);

    localparam int NumDigits = calc_pkg::NumDigits;
    localparam int CntW      = (ClkPerDigit > 1) ? $clog2(ClkPerDigit) : 1;
    localparam int DigW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(ClkPerDigit - 1);
    localparam logic [DigW-1:0] DigLast = DigW'(NumDigits - 1);

    // Reject parameter sets that would make the slot counter meaningless or
    // leave no driven cycles in a slot.
    if (ClkPerDigit < 2 || BlankCycles >= ClkPerDigit) begin : g_param_check
        $error("segment_scanner: need ClkPerDigit >= 2 and BlankCycles < ClkPerDigit");
    end

    logic [CntW-1:0]                   cnt;
    logic [DigW-1:0]                   d;
    logic [NumDigits-1:0][7:0]         snap;

    logic                              slot_end;
    logic                              frame_wrap;
    logic                              drive_off;
    logic [NumDigits-1:0]              digit_sel;
    logic [NumDigits-1:0]              next_anode;
    logic [7:0]                        next_cathode;

    // Slot and frame boundary detection from the current counters.
    always_comb begin
        slot_end   = (cnt == CntLast);
        frame_wrap = slot_end && (d == DigLast);
    end

    // Slot cycle counter and digit index; digit advances when a slot ends.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
            d   <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            d   <= (d == DigLast) ? '0 : d + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame snapshot: capture the whole input only at the frame wrap so the
    // next frame is displayed from one consistent set of digits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snap <= '0;
        end else if (frame_wrap) begin
            snap <= display_segments_i;
        end
    end

`ifdef SEGMENT_SCANNER_BLANK_EN
    localparam logic [CntW-1:0] BlankLim = CntW'(BlankCycles);

    // Display is dark when blanked or during the slot's dead-time window.
    always_comb begin
        drive_off = blank_i || (cnt < BlankLim);
    end
`else
    // Display is dark only when explicitly blanked.
    always_comb begin
        drive_off = blank_i;
    end
`endif

    // Per-cycle drive decision: select the current digit or turn everything off.
    always_comb begin
        digit_sel    = '0;
        digit_sel[d] = 1'b1;
        next_anode   = ~digit_sel;
        next_cathode = ~snap[d];
        if (drive_off) begin
            next_anode   = '1;
            next_cathode = 8'hFF;
        end
    end

    // Register the drive decision and frame pulse so anode, cathode and
    // frame marker all change on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            segments_anode_o   <= '1;
            segments_cathode_o <= 8'hFF;
            frame_o            <= 1'b0;
        end else begin
            segments_anode_o   <= next_anode;
            segments_cathode_o <= next_cathode;
            frame_o            <= frame_wrap;
        end
    end

endmodule
